mem_store_buffer: RTL and testbench

Store buffer between the MEM-stage store path and the data memory write port. It queues word-aligned, byte-enabled stores from the pipeline and drains them to DM at one per acknowledged cycle. It forwards buffered store bytes to MEM-stage loads and stalls a load whose bytes are only partly held in the buffer.

---
 rtl/mem_store_buffer.sv | 111 +++++++++++
 tb/tb_mem_store_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: byte-enabled store FIFO draining to DM, with load forwarding and partial-hit stall.
// Optional SB_COALESCE_EN merges a store into the youngest entry when the word address matches.
module mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [3:0]       st_be,
    input  logic [31:0]      st_pc,
    output logic             st_ready,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    input  logic [3:0]       ld_be,
    output logic             ld_hit,
    output logic [31:0]      ld_data,
    output logic             ld_stall,
    output logic             dm_we,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    output logic [3:0]       dm_be,
    output logic [31:0]      dm_pc,
    input  logic             dm_ack,
    output logic             sb_empty,
    output logic [PTR_W:0]   sb_count
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [29:0]      e_addr [DEPTH];
    logic [31:0]      e_data [DEPTH];
    logic [3:0]       e_be   [DEPTH];
    logic [31:0]      e_pc   [DEPTH];
    logic [PTR_W-1:0] head, tail, young, idx;
    logic [PTR_W:0]   count;
    logic             deq, enq, merge, alloc;
    logic [3:0]       cov, need;
    logic [31:0]      fwd;
    logic             unused_bits;

    assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};
    assign young = tail - PTR_W'(1);
    assign deq   = dm_ack && count != '0;
`ifdef SB_COALESCE_EN
    // The youngest entry is only off-limits when it is also the head leaving this cycle.
    assign merge = count != '0 && e_addr[young] == st_addr[31:2] && !(deq && count == (PTR_W+1)'(1));
`else
    assign merge = 1'b0;
`endif
    assign st_ready = count != FULL || merge;
    assign enq      = st_valid && st_ready && st_be != 4'h0;
    assign alloc    = enq && !merge;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            count <= count + (PTR_W+1)'(alloc) - (PTR_W+1)'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            if (merge) begin
                for (int i = 0; i < 4; i++)
                    if (st_be[i]) e_data[young][8*i +: 8] <= st_data[8*i +: 8];
                e_be[young] <= e_be[young] | st_be;
                e_pc[young] <= st_pc;
            end else begin
                e_addr[tail] <= st_addr[31:2];
                e_data[tail] <= st_data;
                e_be[tail]   <= st_be;
                e_pc[tail]   <= st_pc;
            end
        end
    end

    assign dm_we    = count != '0;
    assign dm_addr  = {e_addr[head], 2'b00};
    assign dm_wdata = e_data[head];
    assign dm_be    = e_be[head];
    assign dm_pc    = e_pc[head];
    assign sb_empty = count == '0;
    assign sb_count = count;

    // Walk oldest to youngest so younger matching bytes overwrite older ones.
    always_comb begin
        cov = '0;
        fwd = '0;
        idx = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            for (int i = 0; i < 4; i++)
                if ((PTR_W+1)'(k) < count && e_addr[idx] == ld_addr[31:2] && e_be[idx][i]) begin
                    cov[i] = 1'b1;
                    fwd[8*i +: 8] = e_data[idx][8*i +: 8];
                end
        end
    end

    assign need     = ld_valid ? ld_be : 4'h0;
    assign ld_hit   = need != 4'h0 && (cov & need) == need;
    assign ld_stall = (cov & need) != 4'h0 && !ld_hit;
    assign ld_data  = ld_hit ? fwd & {{8{need[3]}}, {8{need[2]}}, {8{need[1]}}, {8{need[0]}}} : 32'h0;
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb_mem_store_buffer: table-driven cycle vectors plus a DM-write scoreboard for mem_store_buffer.
module tb_mem_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, st_ready, ld_valid, ld_hit, ld_stall, dm_we, dm_ack, sb_empty;
    logic [31:0] st_addr, st_data, st_pc, ld_addr, ld_data, dm_addr, dm_wdata, dm_pc;
    logic [3:0]  st_be, ld_be, dm_be;
    logic [2:0]  sb_count;

    mem_store_buffer dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_pc(st_pc),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
        .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_pc(dm_pc),
        .dm_ack(dm_ack), .sb_empty(sb_empty), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [31:0] sa, sd;
        logic [3:0]  sbe;
        logic        ack, lv;
        logic [31:0] la;
        logic [3:0]  lbe;
        int          cnt;
        logic        rdy, we, hit, stall;
        logic [31:0] ld;
    } vec_t;

    typedef struct {
        logic [31:0] addr, data;
        logic [3:0]  be;
        logic [31:0] pc;
    } wr_t;

    vec_t vt[$];
    wr_t  sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
        end
    endtask

    task automatic row(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [3:0] sbe,
                       input logic ack, input logic lv, input logic [31:0] la, input logic [3:0] lbe,
                       input int cnt, input logic rdy, input logic we, input logic hit, input logic stall,
                       input logic [31:0] ld);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.sbe = sbe; v.ack = ack;
        v.lv = lv; v.la = la; v.lbe = lbe; v.cnt = cnt;
        v.rdy = rdy; v.we = we; v.hit = hit; v.stall = stall; v.ld = ld;
        vt.push_back(v);
    endtask

    task automatic apply(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [3:0] sbe,
                         input logic [31:0] pc, input logic ack, input logic lv, input logic [31:0] la,
                         input logic [3:0] lbe);
        st_valid = sv; st_addr = sa; st_data = sd; st_be = sbe; st_pc = pc;
        dm_ack = ack; ld_valid = lv; ld_addr = la; ld_be = lbe;
    endtask

    task automatic expect_store(input logic sv, input logic rdy, input logic [31:0] sa, input logic [31:0] sd,
                                input logic [3:0] sbe, input logic [31:0] pc);
        wr_t w;
        if (sv && rdy && sbe != 4'h0) begin
            w.addr = {sa[31:2], 2'b00}; w.data = sd; w.be = sbe; w.pc = pc;
            sb.push_back(w);
        end
    endtask

    // Every DM handshake must match the oldest outstanding accepted store.
    always @(negedge clk) begin
        if (!reset && dm_we && dm_ack) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dm_unexpected: got write to 0x%h want none", dm_addr);
            end else begin
                wr_t w;
                w = sb.pop_front();
                chk("dm_addr", dm_addr, w.addr);
                chk("dm_wdata", dm_wdata, w.data);
                chk("dm_be", {28'h0, dm_be}, {28'h0, w.be});
                chk("dm_pc", dm_pc, w.pc);
            end
        end
    end

    initial begin
        reset = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 32'(sb_count), 0);
        chk("rst_ready", 32'(st_ready), 1);
        chk("rst_we", 32'(dm_we), 0);
        chk("rst_empty", 32'(sb_empty), 1);
        chk("rst_hit", 32'(ld_hit), 0);
        chk("rst_stall", 32'(ld_stall), 0);
        chk("rst_ld_data", ld_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // single store, acked as soon as it shows
        row(1, 'h10, 'hDEADBEEF, 'hF, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        row(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // fill, blocked store while full, then in-order drain
        for (int i = 0; i < 4; i++)
            row(1, 32'(4*i), 32'hA0000000 + 32'(i), 'hF, 0, 0, 0, 0, i, 1, i != 0, 0, 0, 0);
        row(1, 'h100, 'h55, 'hF, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0);
        row(1, 'h100, 'h55, 'hF, 1, 0, 0, 0, 4, 0, 1, 0, 0, 0);
        row(0, 0, 0, 0, 1, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        row(0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 1, 0, 0, 0);
        row(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // forwarding merge; a same-cycle store is invisible to the lookup
        row(1, 'h20, 'h11223344, 'hF, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        row(1, 'h20, 'h000000AA, 'h1, 0, 1, 'h20, 'hF, 1, 1, 1, 1, 0, 'h11223344);
        row(0, 0, 0, 0, 0, 1, 'h22, 'hF, 2, 1, 1, 1, 0, 'h112233AA);
        row(0, 0, 0, 0, 0, 1, 'h20, 'h3, 2, 1, 1, 1, 0, 'h000033AA);
        row(0, 0, 0, 0, 0, 0, 'h20, 'hF, 2, 1, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 'h24, 'hF, 2, 1, 1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 'h20, 'h0, 2, 1, 1, 0, 0, 0);
        row(0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 1, 0, 0, 0);
        row(0, 0, 0, 0, 1, 1, 'h20, 'hF, 1, 1, 1, 0, 1, 0);
        row(0, 0, 0, 0, 0, 1, 'h20, 'hF, 0, 1, 0, 0, 0, 0);
        // partial coverage stall clears once the entry drains
        row(1, 'h40, 'h0000BEEF, 'h3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 'h40, 'hF, 1, 1, 1, 0, 1, 0);
        row(0, 0, 0, 0, 0, 1, 'h40, 'h3, 1, 1, 1, 1, 0, 'h0000BEEF);
        row(0, 0, 0, 0, 0, 1, 'h40, 'h4, 1, 1, 1, 0, 0, 0);
        row(0, 0, 0, 0, 1, 1, 'h40, 'hF, 1, 1, 1, 0, 1, 0);
        row(0, 0, 0, 0, 0, 1, 'h40, 'hF, 0, 1, 0, 0, 0, 0);
        // zero byte-enable store is a no-op
        row(1, 'h50, 'h77, 'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            vec_t v;
            logic [31:0] pc;
            v = vt[i];
            pc = 32'h1000 + 32'(4*i);
            apply(v.sv, v.sa, v.sd, v.sbe, pc, v.ack, v.lv, v.la, v.lbe);
            @(negedge clk);
            chk($sformatf("row%0d_count", i), 32'(sb_count), 32'(v.cnt));
            chk($sformatf("row%0d_empty", i), 32'(sb_empty), 32'(v.cnt == 0));
            chk($sformatf("row%0d_ready", i), 32'(st_ready), 32'(v.rdy));
            chk($sformatf("row%0d_we", i), 32'(dm_we), 32'(v.we));
            chk($sformatf("row%0d_hit", i), 32'(ld_hit), 32'(v.hit));
            chk($sformatf("row%0d_stall", i), 32'(ld_stall), 32'(v.stall));
            chk($sformatf("row%0d_ld_data", i), ld_data, v.ld);
            expect_store(v.sv, v.rdy, v.sa, v.sd, v.sbe, pc);
            @(posedge clk); #1;
        end

        // wrap with simultaneous enqueue and dequeue every cycle
        for (int i = 0; i < 10; i++) begin
            apply(1, 32'h200 + 32'(4*i), 32'hC0DE0000 + 32'(i), 'hF, 32'h2000 + 32'(i), 1, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("wrap%0d_count", i), 32'(sb_count), (i == 0) ? 0 : 1);
            chk($sformatf("wrap%0d_ready", i), 32'(st_ready), 1);
            expect_store(1, 1, st_addr, st_data, st_be, st_pc);
            @(posedge clk); #1;
        end
        apply(0, 0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("wrap_tail_count", 32'(sb_count), 1);
        @(posedge clk); #1;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrap_done_count", 32'(sb_count), 0);
        chk("wrap_drained", 32'(sb.size()), 0);
        @(posedge clk); #1;

        // reset with pending stores discards them
        for (int i = 0; i < 3; i++) begin
            apply(1, 32'h300 + 32'(4*i), 32'h5A000000 + 32'(i), 'hF, 32'h3000 + 32'(i), 0, 0, 0, 0);
            @(negedge clk);
            expect_store(1, 1, st_addr, st_data, st_be, st_pc);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        apply(1, 'h400, 'h99, 'hF, 'h4000, 1, 0, 0, 0);
        @(negedge clk);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        apply(0, 0, 0, 0, 0, 1, 1, 'h300, 'hF);
        @(negedge clk);
        chk("midrst_count", 32'(sb_count), 0);
        chk("midrst_we", 32'(dm_we), 0);
        chk("midrst_ready", 32'(st_ready), 1);
        chk("midrst_empty", 32'(sb_empty), 1);
        chk("midrst_hit", 32'(ld_hit), 0);
        chk("midrst_stall", 32'(ld_stall), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("midrst_idle%0d_we", i), 32'(dm_we), 0);
        end
        chk("final_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
